// File: rtl/fixmul_pkg.sv
// Shared Q16.16 constants and the result word carried through the
// fixmul_scheduler result FIFO.
package fixmul_pkg;

  localparam int FRAC_BITS_DEF = 16;
  localparam int TAG_W_DEF     = 4;

  localparam logic signed [31:0] Q_ONE = 32'sh0001_0000;
  localparam logic signed [31:0] Q_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] Q_MIN = 32'sh8000_0000;

  // One FIFO entry: rescaled product, its user tag, and the saturation flag.
  typedef struct packed {
    logic signed [31:0]     data;
    logic [TAG_W_DEF-1:0]   tag;
    logic                   sat;
  } fixmul_res_t;

endpackage

// File: rtl/fixmul_result_fifo.sv
// Synchronous result FIFO with a registered output stage. Entries sit in a
// circular buffer and are prefetched into the output register one cycle
// after they are written, so there is no write-to-read fall-through.
// count reports buffered entries plus the one held in the output register.
module fixmul_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] mem_cnt;
  logic             load;
  logic             pop;

  // The output register refills whenever it is empty or being consumed.
  assign pop   = rd_valid & rd_ready;
  assign load  = (mem_cnt != '0) & (~rd_valid | rd_ready);
  assign count = mem_cnt + CNT_W'(rd_valid);

  // Pointer, occupancy and output-register control.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr  <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      if (wr_en && !load) begin
        mem_cnt <= mem_cnt + 1'b1;
      end else if (!wr_en && load) begin
        mem_cnt <= mem_cnt - 1'b1;
      end
      if (load) begin
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/fixmul_scheduler.sv
// Issue/collect wrapper around the external non-stallable pipelined 32x32
// signed multiplier. Operands are registered onto mul_a/mul_b, a valid/tag
// delay line tracks each product to mul_p, the product is rescaled to
// Q16.16 with saturation, and results queue in a FIFO. Acceptance is
// throttled by counting in-flight operations against free FIFO space, so
// the FIFO can never overflow while the consumer stalls.
// TAG_W must equal fixmul_pkg::TAG_W_DEF because the FIFO word is the
// package result struct.
module fixmul_scheduler
  import fixmul_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int FRAC_BITS   = FRAC_BITS_DEF,
  parameter int TAG_W       = TAG_W_DEF,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [31:0]      in_a,
  input  logic signed [31:0]      in_b,
  input  logic [TAG_W-1:0]        in_tag,
  output logic signed [31:0]      mul_a,
  output logic signed [31:0]      mul_b,
  input  logic signed [63:0]      mul_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [31:0]      out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_sat
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(MUL_LATENCY + 2);

  logic                   run;
  logic                   accept;
  logic [MUL_LATENCY:0]   vld_p;
  logic [TAG_W-1:0]       tag_p [0:MUL_LATENCY];
  logic [INF_W-1:0]       inflight;
  logic [CNT_W-1:0]       fifo_count;
  logic [CNT_W:0]         credit_used;
  logic                   res_wr;
  fixmul_res_t            wr_word;
  fixmul_res_t            rd_word;

  // Drop FRAC_BITS from the 64-bit product and clamp into the Q16.16 range.
  function automatic fixmul_res_t rescale(input logic signed [63:0] p,
                                          input logic [TAG_W-1:0]   tag);
    logic signed [63:0] r;
    fixmul_res_t        res;
    r       = p >>> FRAC_BITS;
    res.tag = tag;
    if (r > 64'sh0000_0000_7FFF_FFFF) begin
      res.data = Q_MAX;
      res.sat  = 1'b1;
    end else if (r < 64'shFFFF_FFFF_8000_0000) begin
      res.data = Q_MIN;
      res.sat  = 1'b1;
    end else begin
      res.data = r[31:0];
      res.sat  = 1'b0;
    end
    return res;
  endfunction

  // Credits come from registered state only; a same-cycle pop does not help.
  assign credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
  assign in_ready    = run & (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign accept      = in_valid & in_ready;

  // Stage boundary: vld_p[MUL_LATENCY] lines up with mul_p; write on the next edge.
  assign res_wr  = vld_p[MUL_LATENCY];
  assign wr_word = rescale(mul_p, tag_p[MUL_LATENCY]);

  // Control path: run flag, valid delay line, in-flight count, operand registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run      <= 1'b0;
      vld_p    <= '0;
      inflight <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      run   <= 1'b1;
      vld_p <= {vld_p[MUL_LATENCY-1:0], accept};
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      if (accept && !res_wr) begin
        inflight <= inflight + INF_W'(1);
      end else if (!accept && res_wr) begin
        inflight <= inflight - INF_W'(1);
      end
    end
  end

  // Tag delay line; entries are qualified by vld_p so no reset is needed.
  always_ff @(posedge clk) begin
    tag_p[0] <= in_tag;
    for (int i = 1; i <= MUL_LATENCY; i++) begin
      tag_p[i] <= tag_p[i-1];
    end
  end

  // Stage boundary: rescaled results enter the output FIFO.
  fixmul_result_fifo #(
    .WIDTH ($bits(fixmul_res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (res_wr),
    .wr_data  (wr_word),
    .rd_ready (out_ready),
    .rd_valid (out_valid),
    .rd_data  (rd_word),
    .count    (fifo_count)
  );

  assign out_data = rd_word.data;
  assign out_tag  = rd_word.tag;
  assign out_sat  = rd_word.sat;

endmodule

// File: tb/tb_fixmul_scheduler.sv
// Directed self-checking bench for fixmul_scheduler with a behavioural
// 4-stage pipelined multiplier driving mul_p.
module tb_fixmul_scheduler;
  import fixmul_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        sat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_a;
  logic signed [31:0] in_b;
  logic [3:0]         in_tag;
  logic signed [31:0] mul_a;
  logic signed [31:0] mul_b;
  logic signed [63:0] mul_p;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic [3:0]         out_tag;
  logic               out_sat;

  int checks = 0;
  int errors = 0;

  fixmul_scheduler #(
    .MUL_LATENCY (4),
    .FRAC_BITS   (16),
    .TAG_W       (4),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  // External multiplier: product valid 4 edges after the operand registers update.
  logic [63:0] mp1, mp2, mp3, mp4;
  always @(posedge clk) begin
    mp1 <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    mp2 <= mp1;
    mp3 <= mp2;
    mp4 <= mp3;
  end
  assign mul_p = mp4;

  // Reference rescale: returns {sat, data}.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint r;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p >>> 16;
    if (r > 64'sd2147483647) return {1'b1, 32'h7FFF_FFFF};
    if (r < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, r[31:0]};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 4'h0 || out_sat !== 1'b0) begin
      errors++; $display("FAIL reset_out got=%b/%h/%h/%b want=0/0/0/0", out_valid, out_data, out_tag, out_sat);
    end
    checks++;
    if (mul_a !== 32'h0 || mul_b !== 32'h0) begin
      errors++; $display("FAIL reset_mul got=%h/%h want=0/0", mul_a, mul_b);
    end
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_early got=%b want=0", in_ready); end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
  endtask

  // Single operation on an idle block: latency, operands, result, and no extra output.
  task automatic test_one_op(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] tag, input logic [31:0] ed, input logic es);
    int lat;
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got=%b want=1", name, in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (mul_a !== a || mul_b !== b) begin
      errors++; $display("FAIL %s_operands got=%h/%h want=%h/%h", name, mul_a, mul_b, a, b);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != 6) begin errors++; $display("FAIL %s_latency got=%0d want=6", name, lat); end
    checks++;
    if (out_data !== ed || out_tag !== tag || out_sat !== es) begin
      errors++; $display("FAIL %s_result got=%h/%h/%b want=%h/%h/%b", name, out_data, out_tag, out_sat, ed, tag, es);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_single got=%b want=0", name, out_valid); end
  endtask

  task automatic test_basic();
    test_one_op("basic", 32'h0001_8000, 32'h0002_0000, 4'd3, 32'h0003_0000, 1'b0);
  endtask

  task automatic test_sign();
    test_one_op("neg", 32'hFFFE_8000, 32'h0002_0000, 4'd5, 32'hFFFD_0000, 1'b0);
    test_one_op("tiny", 32'h0000_0001, 32'h0000_0001, 4'd6, 32'h0000_0000, 1'b0);
    test_one_op("trunc", 32'hFFFF_FFFF, 32'h0000_0001, 4'd7, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_saturation();
    test_one_op("sat_hi", 32'h7FFF_0000, 32'h0002_0000, 4'd8, 32'h7FFF_FFFF, 1'b1);
    test_one_op("sat_lo", 32'h8000_0000, 32'h0002_0000, 4'd9, 32'h8000_0000, 1'b1);
    test_one_op("sat_sq", 32'h8000_0000, 32'h8000_0000, 4'd10, 32'h7FFF_FFFF, 1'b1);
  endtask

  // 20 ops against a stalled consumer: exactly 8 credits, then in-order drain.
  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    int   idx = 0;
    int   popped = 0;
    int   cyc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (idx < 20) begin
        in_valid = 1'b1; in_a = 32'((idx + 1) << 16); in_b = Q_ONE; in_tag = 4'(idx);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        e.data = 32'((idx + 1) << 16); e.tag = 4'(idx); e.sat = 1'b0;
        q.push_back(e);
        idx++;
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== 32'h0001_0000 || out_tag !== 4'd0) begin
          errors++; $display("FAIL bp_hold got=%h/%h want=00010000/0", out_data, out_tag);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (idx != 8) begin errors++; $display("FAIL bp_accepted got=%0d want=8", idx); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    out_ready = 1'b1;
    while (popped < 20 && cyc < 200) begin
      if (idx < 20) begin
        in_valid = 1'b1; in_a = 32'((idx + 1) << 16); in_b = Q_ONE; in_tag = 4'(idx);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        e.data = 32'((idx + 1) << 16); e.tag = 4'(idx); e.sat = 1'b0;
        q.push_back(e);
        idx++;
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_extra got=%h/%h want=none", out_data, out_tag);
        end else begin
          e = q.pop_front();
          if (out_data !== e.data || out_tag !== e.tag || out_sat !== e.sat) begin
            errors++; $display("FAIL bp_order got=%h/%h want=%h/%h", out_data, out_tag, e.data, e.tag);
          end
        end
        popped++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (popped != 20 || idx != 20) begin
      errors++; $display("FAIL bp_drain got=%0d popped %0d accepted want=20/20", popped, idx);
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b want=0", out_valid); end
  endtask

  // 64 back-to-back ops with the consumer always ready.
  task automatic test_streaming();
    logic [31:0] sa [64];
    logic [31:0] sb [64];
    exp_t        q[$];
    exp_t        e;
    int          idx = 0;
    int          popped = 0;
    int          stalls = 0;
    int          cyc = 0;
    for (int i = 0; i < 64; i++) begin
      sa[i] = $urandom;
      sb[i] = $urandom;
      sa[i] = $signed(sa[i]) >>> (i % 13);
      sb[i] = $signed(sb[i]) >>> (i % 24);
    end
    sa[10] = 32'h7FFF_FFFF; sb[10] = 32'h7FFF_FFFF;
    sa[11] = 32'h8000_0000; sb[11] = 32'h0001_0000;
    out_ready = 1'b1;
    while (popped < 64 && cyc < 120) begin
      if (idx < 64) begin
        in_valid = 1'b1; in_a = sa[idx]; in_b = sb[idx]; in_tag = 4'(idx);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) begin
        {e.sat, e.data} = ref_mul(sa[idx], sb[idx]);
        e.tag = 4'(idx);
        q.push_back(e);
        idx++;
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra got=%h/%h want=none", out_data, out_tag);
        end else begin
          e = q.pop_front();
          if (out_data !== e.data || out_tag !== e.tag || out_sat !== e.sat) begin
            errors++; $display("FAIL stream_result got=%h/%h/%b want=%h/%h/%b",
                               out_data, out_tag, out_sat, e.data, e.tag, e.sat);
          end
        end
        popped++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL stream_stalls got=%0d want=0", stalls); end
    checks++;
    if (popped != 64) begin errors++; $display("FAIL stream_count got=%0d want=64", popped); end
  endtask

  // Reset with operations in flight: nothing from before reset may emerge.
  task automatic test_reset_midflight();
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'h0001_0000 * (i + 1); in_b = Q_ONE; in_tag = 4'(i + 12);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_accept%0d got=%b want=1", i, in_ready); end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid !== 1'b0) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_stale got=%0d cycles valid want=0", seen); end
    test_one_op("post_reset", 32'h0002_0000, 32'h0003_0000, 4'd9, 32'h0006_0000, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_saturation();
    test_backpressure();
    test_streaming();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
